// File: rtl/fifo_burst_reader.sv
// Drains a same-clock sync FIFO in fixed bursts of 1<<BW words onto a valid/ready stream.
// Optional residual flush on timeout is compiled in with `define BURST_TIMEOUT_EN.
module fifo_burst_reader #(
  parameter int unsigned DW  = 8,
  parameter int unsigned AW  = 4,
  parameter int unsigned BW  = 2,
  parameter int unsigned TOW = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [DW-1:0] i_fifo_data,
  input  logic          i_fifo_empty,
  input  logic [AW:0]   i_fifo_fill,
  output logic          o_fifo_rd,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  input  logic          i_ready,
  output logic          o_busy
);

  localparam logic [AW:0] BurstFill = (AW+1)'(1 << BW);
  localparam logic [BW:0] BurstRem  = (BW+1)'(1 << BW);
  localparam logic [BW:0] RemOne    = (BW+1)'(1);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e      state_q;
  logic [BW:0] rem_q;

`ifdef BURST_TIMEOUT_EN
  localparam logic [TOW-1:0] ToMax = '1;
  logic [TOW-1:0] to_q;
`endif

  // Reset gates the pop so words are never lost from the FIFO in the reset cycle.
  assign o_fifo_rd = (state_q == StBurst) && !i_rst && !i_fifo_empty && (!o_valid || i_ready);
  assign o_busy    = (state_q == StBurst);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      rem_q   <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_data  <= '0;
`ifdef BURST_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_fifo_fill >= BurstFill) begin
            state_q <= StBurst;
            rem_q   <= BurstRem;
`ifdef BURST_TIMEOUT_EN
            to_q    <= '0;
          end else if (i_fifo_fill == '0) begin
            to_q <= '0;
          end else if (to_q == ToMax) begin
            // Fill is below a full burst here, so it fits in rem.
            state_q <= StBurst;
            rem_q   <= i_fifo_fill[BW:0];
            to_q    <= '0;
          end else begin
            to_q <= to_q + 1'b1;
`endif
          end
        end
        StBurst: begin
          if (o_fifo_rd) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == RemOne) begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      if (o_fifo_rd) begin
        o_data  <= i_fifo_data;
        o_valid <= 1'b1;
        o_last  <= (rem_q == RemOne);
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

endmodule
